// File: rtl/aabb_collide_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aabb_collide_engine
// Brief    : Pairwise AABB overlap engine; one run per soft-reset release.
//            Optional first-hit index capture: COLLIDE_FIRST_HIT_EN.
// Revision : 1.0
// ============================================================================
module aabb_collide_engine #(
    parameter int ADDR_W  = 6,
    parameter int COORD_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst_n,
    input  logic [ADDR_W-1:0]      num_obj,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd_en,
    input  logic [4*COORD_W-1:0]   mem_rdata,
    output logic                   busy,
    output logic                   done_collide,
    output logic                   hit_flag,
    output logic [2*ADDR_W-1:0]    hit_count,
    output logic [ADDR_W-1:0]      first_i,
    output logic [ADDR_W-1:0]      first_j
);

    localparam int BOX_W = 4 * COORD_W;
    localparam int HC_W  = 2 * ADDR_W;

    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_TWO = ADDR_W'(2);
    localparam logic [HC_W-1:0]   HC_ONE  = HC_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_WAIT_A = 3'd2;
    localparam logic [2:0] S_SCAN   = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] n_obj;
    logic [ADDR_W-1:0] idx_i;
    logic [ADDR_W-1:0] idx_j;
    logic [BOX_W-1:0]  box_a;
    logic              cmp_valid;
    logic              prev_soft;
    logic              short_run;

    logic [COORD_W-1:0] a_xmin, a_xmax, a_ymin, a_ymax;
    logic [COORD_W-1:0] b_xmin, b_xmax, b_ymin, b_ymax;
    logic [ADDR_W-1:0]  n_last;
    logic [ADDR_W-1:0]  i_inc;
    logic               overlap;
    logic               pair_hit;
    logic               start;

    assign a_xmin = box_a[4*COORD_W-1 -: COORD_W];
    assign a_xmax = box_a[3*COORD_W-1 -: COORD_W];
    assign a_ymin = box_a[2*COORD_W-1 -: COORD_W];
    assign a_ymax = box_a[COORD_W-1:0];

    assign b_xmin = mem_rdata[4*COORD_W-1 -: COORD_W];
    assign b_xmax = mem_rdata[3*COORD_W-1 -: COORD_W];
    assign b_ymin = mem_rdata[2*COORD_W-1 -: COORD_W];
    assign b_ymax = mem_rdata[COORD_W-1:0];

    assign n_last   = n_obj - IDX_ONE;
    assign i_inc    = idx_i + IDX_ONE;
    assign overlap  = (a_xmin <= b_xmax) && (b_xmin <= a_xmax) &&
                      (a_ymin <= b_ymax) && (b_ymin <= a_ymax);
    // mem_rdata holds box B only in the cycle after a SCAN read was issued.
    assign pair_hit = cmp_valid && overlap;
    assign start    = (state == S_IDLE) && !prev_soft;
    assign hit_flag = (hit_count != '0);

    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = '0;
        case (state)
            S_LOAD_A: begin
                mem_rd_en = 1'b1;
                mem_addr  = idx_i;
            end
            S_SCAN: begin
                mem_rd_en = 1'b1;
                mem_addr  = idx_j;
            end
            default: begin
                mem_rd_en = 1'b0;
                mem_addr  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            n_obj        <= '0;
            idx_i        <= '0;
            idx_j        <= '0;
            box_a        <= '0;
            cmp_valid    <= 1'b0;
            // Treat soft reset as already released so a held-high level
            // after power-up does not masquerade as a start edge.
            prev_soft    <= 1'b1;
            short_run    <= 1'b0;
            busy         <= 1'b0;
            done_collide <= 1'b0;
            hit_count    <= '0;
        end else if (!soft_rst_n) begin
            state        <= S_IDLE;
            n_obj        <= '0;
            idx_i        <= '0;
            idx_j        <= '0;
            box_a        <= '0;
            cmp_valid    <= 1'b0;
            prev_soft    <= 1'b0;
            short_run    <= 1'b0;
            busy         <= 1'b0;
            done_collide <= 1'b0;
            hit_count    <= '0;
        end else begin
            prev_soft    <= 1'b1;
            done_collide <= 1'b0;
            cmp_valid    <= (state == S_SCAN);

            if (pair_hit && (hit_count != '1)) begin
                hit_count <= hit_count + HC_ONE;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_obj     <= num_obj;
                        idx_i     <= '0;
                        busy      <= 1'b1;
                        hit_count <= '0;
                        if (num_obj < IDX_TWO) begin
                            short_run <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state     <= S_LOAD_A;
                        end
                    end
                end
                S_LOAD_A: begin
                    state <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    box_a <= mem_rdata;
                    idx_j <= i_inc;
                    state <= S_SCAN;
                end
                S_SCAN: begin
                    idx_j <= idx_j + IDX_ONE;
                    if (idx_j == n_last) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    idx_i <= i_inc;
                    state <= (i_inc == n_last) ? S_DONE : S_LOAD_A;
                end
                S_DONE: begin
                    // A trivial run lingers one extra cycle so its pulse
                    // lands two edges after the start edge.
                    if (short_run) begin
                        short_run <= 1'b0;
                    end else begin
                        done_collide <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COLLIDE_FIRST_HIT_EN
    logic [ADDR_W-1:0] b_idx;
    assign b_idx = idx_j - IDX_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_i <= '0;
            first_j <= '0;
        end else if (!soft_rst_n || start) begin
            first_i <= '0;
            first_j <= '0;
        end else if (pair_hit && (hit_count == '0)) begin
            first_i <= idx_i;
            first_j <= b_idx;
        end
    end
`else
    assign first_i = '0;
    assign first_j = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aabb_collide_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aabb_collide_engine
// Brief    : Directed table plus randomized runs against a pairwise model.
// Revision : 1.0
// ============================================================================
module tb_aabb_collide_engine;

    localparam int AW = 6;
    localparam int CW = 10;
    localparam int BW = 4 * CW;

    logic            clk = 1'b0;
    logic            rst;
    logic            soft_rst_n;
    logic [AW-1:0]   num_obj;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd_en;
    logic [BW-1:0]   mem_rdata;
    logic            busy, done_collide, hit_flag;
    logic [2*AW-1:0] hit_count;
    logic [AW-1:0]   first_i, first_j;

    logic [1:0]      mem_addr2;
    logic            mem_rd_en2;
    logic [BW-1:0]   mem_rdata2;
    logic            busy2, done2, hit_flag2;
    logic [3:0]      hit_count2;
    logic [1:0]      first_i2, first_j2;

    logic [BW-1:0]   mem [64];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int                  n;
        logic [3:0][BW-1:0]  boxes;
        int                  exp_cnt;
        int                  exp_lat;
        int                  exp_fi;
        int                  exp_fj;
    } vec_t;

    vec_t vecs[7];

    aabb_collide_engine #(.ADDR_W(AW), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .soft_rst_n(soft_rst_n), .num_obj(num_obj),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .busy(busy), .done_collide(done_collide), .hit_flag(hit_flag),
        .hit_count(hit_count), .first_i(first_i), .first_j(first_j)
    );

    aabb_collide_engine #(.ADDR_W(2), .COORD_W(CW)) dut2 (
        .clk(clk), .rst(rst), .soft_rst_n(soft_rst_n), .num_obj(num_obj[1:0]),
        .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2), .mem_rdata(mem_rdata2),
        .busy(busy2), .done_collide(done2), .hit_flag(hit_flag2),
        .hit_count(hit_count2), .first_i(first_i2), .first_j(first_j2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en)  mem_rdata  <= mem[mem_addr];
        if (mem_rd_en2) mem_rdata2 <= mem[{4'd0, mem_addr2}];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] box(input int x0, input int x1, input int y0, input int y1);
        return {CW'(x0), CW'(x1), CW'(y0), CW'(y1)};
    endfunction

    function automatic bit ovl(input logic [BW-1:0] a, input logic [BW-1:0] b);
        int ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;
        {ax0, ax1, ay0, ay1} = {22'd0, a[39:30], 22'd0, a[29:20], 22'd0, a[19:10], 22'd0, a[9:0]};
        {bx0, bx1, by0, by1} = {22'd0, b[39:30], 22'd0, b[29:20], 22'd0, b[19:10], 22'd0, b[9:0]};
        return (ax0 <= bx1) && (bx0 <= ax1) && (ay0 <= by1) && (by0 <= ay1);
    endfunction

    // Reference: every pair i<j in scan order, plus the closed-form latency.
    task automatic model(input int n, output int cnt, output int lat, output int fi, output int fj);
        cnt = 0; fi = 0; fj = 0;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                if (ovl(mem[a], mem[b])) begin
                    if (cnt == 0) begin fi = a; fj = b; end
                    cnt++;
                end
        if (n < 2) lat = 2;
        else begin
            lat = 1;
            for (int a = 0; a <= n - 2; a++) lat += n + 2 - a;
        end
    endtask

    function automatic vec_t mk(input int n, input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                                input logic [BW-1:0] b2, input logic [BW-1:0] b3,
                                input int c, input int l, input int fi, input int fj);
        vec_t v;
        v.n = n; v.boxes[0] = b0; v.boxes[1] = b1; v.boxes[2] = b2; v.boxes[3] = b3;
        v.exp_cnt = c; v.exp_lat = l; v.exp_fi = fi; v.exp_fj = fj;
        return v;
    endfunction

    task automatic run(input int n, input int ecnt, input int elat, input int efi, input int efj);
        int exp_tr[$];
        int got_tr[$];
        int lat, lat2, busy_err, tr_err, tr_idx, efi_x, efj_x;
        @(negedge clk);
        soft_rst_n = 1'b0;
        num_obj    = AW'(n);
        repeat (2) @(negedge clk);
        check("clear_hit_count", hit_count, 0);
        soft_rst_n = 1'b1;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        if (n < 2) exp_tr = '{-1, -1};
        else begin
            for (int a = 0; a <= n - 2; a++) begin
                exp_tr.push_back(a);
                exp_tr.push_back(-1);
                for (int b = a + 1; b < n; b++) exp_tr.push_back(b);
                exp_tr.push_back(-1);
            end
            exp_tr.push_back(-1);
        end
        lat = -1; lat2 = -1; busy_err = 0;
        got_tr.push_back(mem_rd_en ? int'(mem_addr) : -1);
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (done2 && lat2 < 0) lat2 = c;
            if (done_collide) begin lat = c; break; end
            if (!busy) busy_err++;
            got_tr.push_back(mem_rd_en ? int'(mem_addr) : -1);
        end
        check("latency", lat, elat);
        check("busy_during_run", busy_err, 0);
        check("busy_at_done", busy, 0);
        check("hit_count", hit_count, (ecnt > 4095) ? 4095 : ecnt);
        check("hit_flag", hit_flag, (ecnt != 0) ? 1 : 0);
`ifdef COLLIDE_FIRST_HIT_EN
        efi_x = efi; efj_x = efj;
`else
        efi_x = 0; efj_x = 0;
`endif
        check("first_i", first_i, efi_x);
        check("first_j", first_j, efj_x);
        tr_err = 0; tr_idx = -1;
        if (got_tr.size() != exp_tr.size()) tr_err = 1;
        else
            for (int k = 0; k < exp_tr.size(); k++)
                if (got_tr[k] != exp_tr[k]) begin
                    tr_err++;
                    if (tr_idx < 0) tr_idx = k;
                end
        if (tr_err != 0)
            $display("read trace differs at index %0d (len %0d vs %0d)", tr_idx, got_tr.size(), exp_tr.size());
        check("read_trace", tr_err, 0);
        if (n <= 3) begin
            check("w2_latency", lat2, elat);
            check("w2_hit_count", hit_count2, ecnt);
            check("w2_first_j", first_j2, efj_x);
        end
        @(negedge clk);
        check("done_one_cycle", done_collide, 0);
        repeat (3) @(negedge clk);
        check("hit_held", hit_count, (ecnt > 4095) ? 4095 : ecnt);
        check("no_restart", busy, 0);
    endtask

    initial begin
        int cnt, lat, fi, fj, seen;

        vecs[0] = mk(3, box(0,5,0,5),    box(5,9,5,9),      box(20,30,20,30), box(0,0,0,0),  1, 10, 0, 1);
        vecs[1] = mk(4, box(0,10,0,10),  box(0,10,0,10),    box(0,10,0,10),   box(0,10,0,10), 6, 16, 0, 1);
        vecs[2] = mk(1, box(0,10,0,10),  box(0,10,0,10),    box(0,0,0,0),     box(0,0,0,0),  0, 2, 0, 0);
        vecs[3] = mk(0, box(0,10,0,10),  box(0,10,0,10),    box(0,0,0,0),     box(0,0,0,0),  0, 2, 0, 0);
        vecs[4] = mk(3, box(0,1,0,1),    box(3,4,3,4),      box(6,7,6,7),     box(0,0,0,0),  0, 10, 0, 0);
        vecs[5] = mk(3, box(0,1,0,1),    box(10,20,10,20),  box(20,30,0,10),  box(0,0,0,0),  1, 10, 1, 2);
        vecs[6] = mk(2, box(0,5,0,5),    box(5,9,6,9),      box(0,0,0,0),     box(0,0,0,0),  0, 5, 0, 0);

        for (int k = 0; k < 64; k++) mem[k] = '0;
        rst = 1'b0; soft_rst_n = 1'b1; num_obj = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done_collide, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_first_i", first_i, 0);
        @(negedge clk);
        rst = 1'b1;
        num_obj = AW'(3);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || done_collide || mem_rd_en) seen++;
        end
        check("no_start_without_edge", seen, 0);

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 4; k++) mem[k] = vecs[v].boxes[k];
            run(vecs[v].n, vecs[v].exp_cnt, vecs[v].exp_lat, vecs[v].exp_fi, vecs[v].exp_fj);
        end

        // Abort in the middle of the first scan, then a full rerun.
        for (int k = 0; k < 8; k++) mem[k] = box(0, 10, 0, 10);
        @(negedge clk);
        soft_rst_n = 1'b0; num_obj = AW'(8);
        repeat (2) @(negedge clk);
        soft_rst_n = 1'b1;
        @(negedge clk);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_collide) seen++;
        end
        check("pre_abort_hits", (hit_count != 0) ? 1 : 0, 1);
        soft_rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_hit_count", hit_count, 0);
        check("abort_rd_en", mem_rd_en, 0);
        repeat (20) begin
            @(negedge clk);
            if (done_collide) seen++;
        end
        check("abort_no_done", seen, 0);
        model(8, cnt, lat, fi, fj);
        run(8, cnt, lat, fi, fj);

        // Asynchronous reset mid-run clears between edges.
        @(negedge clk);
        soft_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        soft_rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_hit_count", hit_count, 0);
        check("async_rd_en", mem_rd_en, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (busy || done_collide) seen++;
        end
        check("async_no_done", seen, 0);

        for (int r = 0; r < 25; r++) begin
            int n, x0, y0;
            n = $urandom_range(0, 12);
            for (int k = 0; k < 12; k++) begin
                x0 = $urandom_range(0, 60);
                y0 = $urandom_range(0, 60);
                if ($urandom_range(0, 7) == 0)
                    mem[k] = box(x0 + 5, x0, y0, y0 + $urandom_range(0, 20));
                else
                    mem[k] = box(x0, x0 + $urandom_range(0, 20), y0, y0 + $urandom_range(0, 20));
            end
            model(n, cnt, lat, fi, fj);
            run(n, cnt, lat, fi, fj);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
